avalon_pio_ext: RTL and testbench
=================================

// Module: avalon_pio_ext
// PURPOSE
//  Parametrised Avalon-MM slave PIO, successor to the fixed 8-bit output PIO.
//  - Generic width; output, input or bidirectional pins; per-bit direction.
//  - Atomic set/clear of output bits.
//  - Input synchroniser, edge capture and maskable interrupt.
//  - Sits on the Avalon-MM interconnect as a zero-wait, read-latency-1 slave.
// PARAMETERS
//  WIDTH        8   pin count, 1..32
//  HAS_OUT      1   output register present (0: out_port/out_oe tied 0)
//  HAS_IN       1   input path present (0: in_port ignored, reads 0)
//  BIDIR        0   1: per-bit direction register drives out_oe
//  RESET_VALUE  0   reset value of data_out[WIDTH-1:0]
//  EDGE_TYPE    1   0 none, 1 rising, 2 falling, 3 any
//  IRQ_TYPE     2   0 none, 1 level (sync input), 2 edge (capture reg)
//  SYNC_STAGES  2   input synchroniser depth, >=2
// PORTS
//  clk        in   1      single clock
//  reset      in   1      async, active-high
//  address    in   3      word address
//  chipselect in   1      slave select
//  write_n    in   1      write strobe, active-low
//  read_n     in   1      read strobe, active-low
//  writedata  in   32     write data; bits >= WIDTH ignored
//  readdata   out  32     read data, valid 1 cycle after read
//  in_port    in   WIDTH  external inputs, asynchronous
//  out_port   out  WIDTH  output pin values
//  out_oe     out  WIDTH  per-bit output enable
//  irq        out  1      interrupt, active-high, registered
// BEHAVIOUR
//  Reset
//  - Async, active-high.
//  - data_out=RESET_VALUE; dir=0; mask=0; edge_cap=0; sync chain=0; readdata=0; irq=0.
//  - Reset mid-access aborts the access; no register keeps partial state.
//  Register map
//  - wr = chipselect & ~write_n; rd = chipselect & ~read_n.
//  - 0 DATA: rd -> in_sync if HAS_IN else data_out; wr -> data_out.
//  - 1 DIR: rd/wr dir. Exists only if BIDIR; otherwise reads 0, writes ignored.
//  - 2 MASK: rd/wr irq mask.
//  - 3 EDGE: rd -> edge_cap; wr -> clears bits written as 1 (W1C).
//  - 4 OUTSET: wr -> data_out |= wd. Reads 0.
//  - 5 OUTCLR: wr -> data_out &= ~wd. Reads 0.
//  - 6,7: reserved; read 0, writes ignored.
//  Write timing
//  - A write takes effect at the next clk edge; out_port updates that edge.
//  Read timing
//  - readdata registered; holds the selected value the cycle after rd.
//  - readdata holds its last value when no rd is active.
//  - Upper bits [31:WIDTH] are always 0.
//  - A read and a write in the same cycle are impossible (single port).
//  Outputs
//  - out_oe = BIDIR ? dir : {WIDTH{HAS_OUT}}.
//  - out_port = data_out.
//  Input path
//  - in_port passes SYNC_STAGES flops -> in_sync; in_prev = in_sync delayed 1 cycle.
//  - rise = in_sync & ~in_prev; fall = ~in_sync & in_prev.
//  - edge_cap bit sets on the edge selected by EDGE_TYPE.
//  - Total latency from pin to edge_cap = SYNC_STAGES+1 cycles.
//  - Set wins over W1C: an edge and a clear of the same bit in one cycle leave the bit 1.
//  - Bits not written 1 are unaffected by EDGE writes.
//  Interrupt
//  - irq_next = |(mask & (IRQ_TYPE==1 ? in_sync : edge_cap)).
//  - irq registered from irq_next (1 cycle late); irq=0 when IRQ_TYPE==0.
//  - Clearing edge_cap or mask drops irq one cycle after the write edge.
//  Width rules
//  - All internal registers are WIDTH bits; writedata truncated to [WIDTH-1:0].
// STRUCTURE
//  - Package avalon_pio_pkg:
//    - address constants PIO_DATA..PIO_OUTCLR;
//    - EDGE_* and IRQ_* encodings;
//    - PIO_ADDR_W = 3.
//  - Sub-module pio_in_sync(WIDTH, SYNC_STAGES, EDGE_TYPE): synchroniser plus
//    rise/fall detect; outputs in_sync and edge_pulse.
//  - Top level holds the register file, read mux and irq flop.
// TESTING
//  1. Reset, WIDTH=8, RESET_VALUE=8'hA5: out_port=A5, irq=0, readdata=0.
//     Read addr3 -> 0.
//  2. Write DATA=0x0F, OUTSET=0xF0 -> out_port=0xFF; OUTCLR=0x81 -> 0x7E.
//     Read DATA with HAS_IN=0 -> 0x7E on the cycle after rd.
//  3. EDGE_TYPE=1, mask=0x01: in_port[0] 0->1 -> edge_cap=0x01 after 3 cycles.
//     irq=1 one cycle later.
//     Write EDGE=0x01 -> edge_cap=0, irq=0 next cycle.
//  4. EDGE W1C of bit0 in the same cycle as a new rising edge on bit0
//     -> edge_cap[0] stays 1 and irq stays 1.
//  5. BIDIR=1: write DIR=0x0C -> out_oe=0x0C. Write 0xFFFFFF0C to DIR
//     -> upper bits dropped; read DIR -> 0x0000000C.
//  6. IRQ_TYPE=1, mask=0x80: hold in_port[7]=1 -> irq=1 while held;
//     assert reset mid-pulse -> irq=0, mask=0 asynchronously.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// ---------------------------------------------------------------------------
// avalon_pio_pkg
//
// Shared definitions for the extended Avalon-MM PIO:
//   - word addresses of the slave register map
//   - encodings of the EDGE_TYPE and IRQ_TYPE parameters
//   - address bus width
// ---------------------------------------------------------------------------
package avalon_pio_pkg;

    // Width of the Avalon word address
    localparam int PIO_ADDR_W = 3;

    // Register map (word addresses); 6 and 7 are reserved
    localparam logic [PIO_ADDR_W-1:0] PIO_DATA   = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_DIR    = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_MASK   = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_EDGE   = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_OUTSET = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_OUTCLR = 3'd5;

    // Which synchronised input transitions set the edge-capture register
    localparam int EDGE_NONE    = 0;
    localparam int EDGE_RISING  = 1;
    localparam int EDGE_FALLING = 2;
    localparam int EDGE_ANY     = 3;

    // Source of the interrupt request
    localparam int IRQ_NONE  = 0;
    localparam int IRQ_LEVEL = 1;
    localparam int IRQ_EDGE  = 2;

endpackage

// File: rtl/pio_in_sync.sv
// ---------------------------------------------------------------------------
// pio_in_sync
//
// Multi-flop synchroniser for the asynchronous PIO input pins, followed by a
// one-cycle delay used to detect transitions of the synchronised value.
//
// Ports
//   clk         single clock
//   reset       asynchronous, active-high; clears the whole chain
//   in_port     raw asynchronous pin values
//   in_sync     pin values after SYNC_STAGES flops
//   edge_pulse  one-cycle pulse per bit on the transition chosen by EDGE_TYPE
// ---------------------------------------------------------------------------
module pio_in_sync
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  prev_d;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;

    // Stage 0 samples the pin; each later stage copies the previous one.
    // prev holds the synchronised value from one cycle earlier.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Transition detect on the synchronised value; only the selected kind
    // of transition is reported to the capture register.
    always_comb begin
        rise = in_sync & ~prev_q;
        fall = ~in_sync & prev_q;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_pulse = rise;
            EDGE_FALLING: edge_pulse = fall;
            EDGE_ANY:     edge_pulse = rise | fall;
            default:      edge_pulse = '0;
        endcase
    end

endmodule

// File: rtl/avalon_pio_ext.sv
// ---------------------------------------------------------------------------
// avalon_pio_ext
//
// Parametrised Avalon-MM slave PIO: generic width, output / input /
// bidirectional pins, atomic set and clear of output bits, synchronised
// inputs with edge capture and a maskable registered interrupt.
// Zero-wait writes, read latency of one cycle.
//
// Ports
//   clk         single clock
//   reset       asynchronous, active-high
//   address     word address (see avalon_pio_pkg)
//   chipselect  slave select
//   write_n     write strobe, active-low
//   read_n      read strobe, active-low
//   writedata   write data; bits at and above WIDTH are ignored
//   readdata    registered read data, valid the cycle after a read
//   in_port     asynchronous external inputs
//   out_port    output pin values
//   out_oe      per-bit output enable
//   irq         active-high registered interrupt
// ---------------------------------------------------------------------------
module avalon_pio_ext
    import avalon_pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          HAS_OUT     = 1,
    parameter int          HAS_IN      = 1,
    parameter int          BIDIR       = 0,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          EDGE_TYPE   = EDGE_RISING,
    parameter int          IRQ_TYPE    = IRQ_EDGE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIO_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic                  read_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [WIDTH-1:0]      in_port,
    output logic [WIDTH-1:0]      out_port,
    output logic [WIDTH-1:0]      out_oe,
    output logic                  irq
);

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;

    logic [WIDTH-1:0] in_gated;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;

    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] dir_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic [WIDTH-1:0] rd_sel;
    logic             irq_q;
    logic             irq_d;

    assign wr = chipselect & ~write_n;
    assign rd = chipselect & ~read_n;
    assign wd = writedata[WIDTH-1:0];

    // Upper write-data bits are intentionally dropped
    assign unused_wd = &{1'b0, writedata};

    // Without an input path the pins are ignored entirely, so nothing
    // downstream (DATA reads, edges, level irq) ever sees them.
    assign in_gated = (HAS_IN != 0) ? in_port : '0;

    pio_in_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_in_sync (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_gated),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    // Register-file write decode. OUTSET/OUTCLR modify only the bits
    // written as 1, giving atomic bit manipulation without read-modify-write.
    // Direction is only writable when the part is built bidirectional.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        edge_clr   = '0;
        if (wr) begin
            case (address)
                PIO_DATA:   data_out_d = wd;
                PIO_DIR:    if (BIDIR != 0) dir_d = wd;
                PIO_MASK:   mask_d = wd;
                PIO_EDGE:   edge_clr = wd;
                PIO_OUTSET: data_out_d = data_out_q | wd;
                PIO_OUTCLR: data_out_d = data_out_q & ~wd;
                default:    ;
            endcase
        end
        // A newly detected edge is applied after the clear, so a bit that is
        // cleared and re-triggered in the same cycle ends up set.
        edge_d = (edge_q & ~edge_clr) | edge_pulse;
    end

    // Read mux. readdata only reloads on a read and otherwise holds, and the
    // value is zero-extended so bits above WIDTH always read 0.
    always_comb begin
        case (address)
            PIO_DATA: begin
                if (HAS_IN != 0)
                    rd_sel = in_sync;
                else if (HAS_OUT != 0)
                    rd_sel = data_out_q;
                else
                    rd_sel = '0;
            end
            PIO_DIR:  rd_sel = (BIDIR != 0) ? dir_q : '0;
            PIO_MASK: rd_sel = mask_q;
            PIO_EDGE: rd_sel = edge_q;
            default:  rd_sel = '0;
        endcase
        readdata_d = rd ? 32'(rd_sel) : readdata_q;
    end

    // Interrupt source is either the live synchronised level or the sticky
    // capture register; the request is registered, so it follows a change of
    // mask or capture state by one cycle.
    always_comb begin
        case (IRQ_TYPE)
            IRQ_LEVEL: irq_d = |(mask_q & in_sync);
            IRQ_EDGE:  irq_d = |(mask_q & edge_q);
            default:   irq_d = 1'b0;
        endcase
    end

    // All architectural state resets asynchronously, which also abandons any
    // access that was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= RESET_VALUE[WIDTH-1:0];
            dir_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    // Pin outputs: with no output register the pins are never driven.
    assign out_port = (HAS_OUT != 0) ? data_out_q : '0;
    assign out_oe   = (BIDIR != 0) ? dir_q : {WIDTH{HAS_OUT != 0}};
    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_ext.sv
// ---------------------------------------------------------------------------
// tb_avalon_pio_ext
//
// Three instances share one bus (separate chipselects):
//   A: bidirectional, input path, rising-edge capture, edge irq, reset A5
//   B: output only (no input path), reset A5
//   C: input path, level irq
// A is also tracked every cycle by a behavioural model written from the
// register-map rules.
// ---------------------------------------------------------------------------
module tb_avalon_pio_ext;
    import avalon_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic        cs_a, cs_b, cs_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic [7:0]  in_a, in_b, in_c;
    logic [7:0]  out_a, out_b, out_c;
    logic [7:0]  oe_a, oe_b, oe_c;
    logic        irq_a, irq_b, irq_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    avalon_pio_ext #(
        .WIDTH(8), .HAS_OUT(1), .HAS_IN(1), .BIDIR(1), .RESET_VALUE(32'hA5),
        .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_EDGE), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_a),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(rdata_a), .in_port(in_a), .out_port(out_a), .out_oe(oe_a),
        .irq(irq_a)
    );

    avalon_pio_ext #(
        .WIDTH(8), .HAS_OUT(1), .HAS_IN(0), .BIDIR(0), .RESET_VALUE(32'hA5),
        .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_EDGE), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_b),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(rdata_b), .in_port(in_b), .out_port(out_b), .out_oe(oe_b),
        .irq(irq_b)
    );

    avalon_pio_ext #(
        .WIDTH(8), .HAS_OUT(1), .HAS_IN(1), .BIDIR(0), .RESET_VALUE(32'h0),
        .EDGE_TYPE(EDGE_RISING), .IRQ_TYPE(IRQ_LEVEL), .SYNC_STAGES(2)
    ) dut_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs_c),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(rdata_c), .in_port(in_c), .out_port(out_c), .out_oe(oe_c),
        .irq(irq_c)
    );

    // Reference model of instance A. A pin value present at one clock edge
    // becomes the synchronised value two edges later (h2), and an edge is
    // captured when that synchronised value goes 0 -> 1 (h2 & ~h3).
    logic [7:0]  m_data, m_dir, m_mask, m_edge;
    logic [7:0]  h1, h2, h3;
    logic        m_irq;
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_data  = 8'hA5;
        m_dir   = 8'h00;
        m_mask  = 8'h00;
        m_edge  = 8'h00;
        m_irq   = 1'b0;
        m_rdata = 32'h0;
        h1 = 8'h00; h2 = 8'h00; h3 = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] wd;
        logic [7:0] clr;
        logic [7:0] new_edges;
        wd        = writedata[7:0];
        clr       = 8'h00;
        new_edges = h2 & ~h3;
        m_irq     = |(m_mask & m_edge);
        if (cs_a && !read_n) begin
            case (address)
                3'd0:    m_rdata = {24'h0, h2};
                3'd1:    m_rdata = {24'h0, m_dir};
                3'd2:    m_rdata = {24'h0, m_mask};
                3'd3:    m_rdata = {24'h0, m_edge};
                default: m_rdata = 32'h0;
            endcase
        end
        if (cs_a && !write_n) begin
            case (address)
                3'd0:    m_data = wd;
                3'd1:    m_dir  = wd;
                3'd2:    m_mask = wd;
                3'd3:    clr    = wd;
                3'd4:    m_data = m_data | wd;
                3'd5:    m_data = m_data & ~wd;
                default: ;
            endcase
        end
        m_edge = (m_edge & ~clr) | new_edges;
        h3 = h2; h2 = h1; h1 = in_a;
    endtask

    // One clock: the model consumes the same inputs the DUTs see at the
    // edge, then the bench continues 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic bus_idle();
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
        write_n = 1'b1; read_n = 1'b1;
    endtask

    // sel bit 0 -> A, bit 1 -> B, bit 2 -> C
    task automatic bus_write(input logic [2:0] sel, input logic [2:0] addr, input logic [31:0] data);
        cs_a = sel[0]; cs_b = sel[1]; cs_c = sel[2];
        address = addr; writedata = data; write_n = 1'b0;
        cycle();
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] sel, input logic [2:0] addr);
        cs_a = sel[0]; cs_b = sel[1]; cs_c = sel[2];
        address = addr; read_n = 1'b0;
        cycle();
        bus_idle();
    endtask

    task automatic test_reset();
        repeat (2) cycle();
        tests_run++; if (out_a !== 8'hA5) begin tests_failed++; $display("[TB] FAIL reset_out_a: got %h expected a5", out_a); end
        tests_run++; if (irq_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_irq_a: got %b expected 0", irq_a); end
        tests_run++; if (rdata_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata_a: got %h expected 0", rdata_a); end
        tests_run++; if (oe_a !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_oe_a: got %h expected 00", oe_a); end
        tests_run++; if (out_b !== 8'hA5 || oe_b !== 8'hFF || irq_b !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_b: got out=%h oe=%h irq=%b expected a5/ff/0", out_b, oe_b, irq_b); end
        tests_run++; if (out_c !== 8'h00 || oe_c !== 8'hFF) begin tests_failed++; $display("[TB] FAIL reset_c: got out=%h oe=%h expected 00/ff", out_c, oe_c); end
        reset = 1'b0;
        cycle();
        bus_read(3'b001, PIO_EDGE);
        tests_run++; if (rdata_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_read_edge: got %h expected 0", rdata_a); end
    endtask

    task automatic test_set_clear();
        bus_write(3'b010, PIO_DATA, 32'h0000_000F);
        tests_run++; if (out_b !== 8'h0F) begin tests_failed++; $display("[TB] FAIL data_write: got %h expected 0f", out_b); end
        bus_write(3'b010, PIO_OUTSET, 32'h0000_00F0);
        tests_run++; if (out_b !== 8'hFF) begin tests_failed++; $display("[TB] FAIL outset: got %h expected ff", out_b); end
        bus_write(3'b010, PIO_OUTCLR, 32'h0000_0081);
        tests_run++; if (out_b !== 8'h7E) begin tests_failed++; $display("[TB] FAIL outclr: got %h expected 7e", out_b); end
        tests_run++; if (rdata_b !== 32'h0) begin tests_failed++; $display("[TB] FAIL rdata_before_read: got %h expected 0", rdata_b); end
        bus_read(3'b010, PIO_DATA);
        tests_run++; if (rdata_b !== 32'h0000_007E) begin tests_failed++; $display("[TB] FAIL read_data_no_in: got %h expected 7e", rdata_b); end
        repeat (2) cycle();
        tests_run++; if (rdata_b !== 32'h0000_007E) begin tests_failed++; $display("[TB] FAIL readdata_hold: got %h expected 7e", rdata_b); end
        bus_read(3'b010, PIO_OUTSET);
        tests_run++; if (rdata_b !== 32'h0) begin tests_failed++; $display("[TB] FAIL read_outset: got %h expected 0", rdata_b); end
    endtask

    task automatic test_edge_irq();
        bus_write(3'b001, PIO_MASK, 32'h0000_0001);
        in_a = 8'h01;
        repeat (3) cycle();
        tests_run++; if (irq_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL irq_too_early: got %b expected 0", irq_a); end
        cycle();
        tests_run++; if (irq_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_rise: got %b expected 1", irq_a); end
        bus_read(3'b001, PIO_EDGE);
        tests_run++; if (rdata_a !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL edge_cap_set: got %h expected 1", rdata_a); end
        bus_write(3'b001, PIO_EDGE, 32'h0000_0001);
        tests_run++; if (irq_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_clear_latency: got %b expected 1", irq_a); end
        cycle();
        tests_run++; if (irq_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL irq_cleared: got %b expected 0", irq_a); end
        bus_read(3'b001, PIO_EDGE);
        tests_run++; if (rdata_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL edge_cap_cleared: got %h expected 0", rdata_a); end
    endtask

    task automatic test_w1c_collision();
        in_a = 8'h00;
        repeat (4) cycle();
        in_a = 8'h01;
        repeat (5) cycle();
        tests_run++; if (irq_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL collision_setup_irq: got %b expected 1", irq_a); end
        in_a = 8'h00;
        repeat (4) cycle();
        // The new rise reaches the capture register on the third edge,
        // the same edge that carries the W1C write.
        in_a = 8'h01;
        repeat (2) cycle();
        bus_write(3'b001, PIO_EDGE, 32'h0000_0001);
        repeat (2) cycle();
        tests_run++; if (irq_a !== 1'b1) begin tests_failed++; $display("[TB] FAIL collision_irq: got %b expected 1", irq_a); end
        bus_read(3'b001, PIO_EDGE);
        tests_run++; if (rdata_a !== 32'h0000_0001) begin tests_failed++; $display("[TB] FAIL collision_edge_cap: got %h expected 1", rdata_a); end
        bus_write(3'b001, PIO_EDGE, 32'h0000_0001);
        repeat (2) cycle();
        tests_run++; if (irq_a !== 1'b0) begin tests_failed++; $display("[TB] FAIL collision_cleanup: got %b expected 0", irq_a); end
    endtask

    task automatic test_bidir();
        bus_write(3'b001, PIO_DIR, 32'h0000_000C);
        tests_run++; if (oe_a !== 8'h0C) begin tests_failed++; $display("[TB] FAIL dir_oe: got %h expected 0c", oe_a); end
        bus_write(3'b001, PIO_DIR, 32'hFFFF_FF0C);
        bus_read(3'b001, PIO_DIR);
        tests_run++; if (rdata_a !== 32'h0000_000C) begin tests_failed++; $display("[TB] FAIL dir_truncate: got %h expected 0000000c", rdata_a); end
        bus_read(3'b001, 3'd6);
        tests_run++; if (rdata_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reserved_read: got %h expected 0", rdata_a); end
        bus_write(3'b010, PIO_DIR, 32'h0000_0000);
        bus_read(3'b010, PIO_DIR);
        tests_run++; if (oe_b !== 8'hFF || rdata_b !== 32'h0) begin tests_failed++; $display("[TB] FAIL no_dir_reg: got oe=%h rd=%h expected ff/0", oe_b, rdata_b); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int op;
            if ($urandom_range(0, 3) == 0) in_a = 8'($urandom);
            op = $urandom_range(0, 2);
            address   = 3'($urandom_range(0, 7));
            writedata = $urandom;
            cs_a      = (op != 0);
            write_n   = (op != 1);
            read_n    = (op != 2);
            cycle();
            bus_idle();
            tests_run++; if (out_a !== m_data) begin tests_failed++; $display("[TB] FAIL rand_out_port[%0d]: got %h expected %h", i, out_a, m_data); end
            tests_run++; if (oe_a !== m_dir) begin tests_failed++; $display("[TB] FAIL rand_out_oe[%0d]: got %h expected %h", i, oe_a, m_dir); end
            tests_run++; if (irq_a !== m_irq) begin tests_failed++; $display("[TB] FAIL rand_irq[%0d]: got %b expected %b", i, irq_a, m_irq); end
            tests_run++; if (rdata_a !== m_rdata) begin tests_failed++; $display("[TB] FAIL rand_readdata[%0d]: got %h expected %h", i, rdata_a, m_rdata); end
        end
    endtask

    task automatic test_level_irq_reset();
        bus_write(3'b100, PIO_MASK, 32'h0000_0080);
        in_c = 8'h80;
        repeat (2) cycle();
        tests_run++; if (irq_c !== 1'b0) begin tests_failed++; $display("[TB] FAIL level_irq_early: got %b expected 0", irq_c); end
        cycle();
        tests_run++; if (irq_c !== 1'b1) begin tests_failed++; $display("[TB] FAIL level_irq_set: got %b expected 1", irq_c); end
        repeat (3) cycle();
        tests_run++; if (irq_c !== 1'b1) begin tests_failed++; $display("[TB] FAIL level_irq_held: got %b expected 1", irq_c); end
        // Start a mask write, then reset before the clock edge arrives.
        cs_c = 1'b1; address = PIO_MASK; writedata = 32'h0000_00FF; write_n = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        tests_run++; if (irq_c !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset_irq: got %b expected 0", irq_c); end
        tests_run++; if (out_a !== m_data) begin tests_failed++; $display("[TB] FAIL async_reset_out_a: got %h expected %h", out_a, m_data); end
        bus_idle();
        cycle();
        reset = 1'b0;
        bus_read(3'b100, PIO_MASK);
        tests_run++; if (rdata_c !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mask: got %h expected 0", rdata_c); end
        repeat (4) cycle();
        tests_run++; if (irq_c !== 1'b0) begin tests_failed++; $display("[TB] FAIL irq_after_reset: got %b expected 0", irq_c); end
    endtask

    initial begin
        reset = 1'b1;
        address = 3'd0; writedata = 32'h0;
        in_a = 8'h00; in_b = 8'h00; in_c = 8'h00;
        bus_idle();
        model_reset();
        test_reset();
        test_set_clear();
        test_edge_irq();
        test_w1c_collision();
        test_bidir();
        test_random();
        test_level_irq_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
